// File: rtl/projectile_scheduler.sv
// Projectile scheduler: one shared projectile slot for a two-player playfield.
// Players request fire; an eligible request is granted round-robin.
// The projectile then moves one column per tick toward the opponent's edge.
// On reaching the far edge it resolves as a hit or a miss.
//
// Handshake: fire_req is a level request.
// A request is taken only in IDLE, when that player's cooldown is zero.
// The grant is a one-cycle fire_grant pulse on the cycle after the request
// is accepted. Requests seen while a projectile exists are dropped, not queued.
module projectile_scheduler #(
  parameter int FIELD_W  = 16,
  parameter int COOLDOWN = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic [1:0] fire_req,
  input  logic [2:0] player_row_0,
  input  logic [2:0] player_row_1,
  output logic [1:0] fire_grant,
  output logic       proj_active,
  output logic       proj_owner,
  output logic [3:0] proj_col,
  output logic [2:0] proj_row,
  output logic [1:0] hit,
  output logic       miss,
  output logic [1:0] dbg_state
);

  localparam int CD_W = $clog2(COOLDOWN + 1);
  localparam logic [CD_W-1:0] CD_LOAD = CD_W'(COOLDOWN);
  localparam logic [CD_W-1:0] CD_ONE  = CD_W'(1);
  localparam logic [3:0] COL_START0 = 4'd1;
  localparam logic [3:0] COL_START1 = 4'(FIELD_W - 2);
  localparam logic [3:0] COL_TERM0  = 4'(FIELD_W - 1);
  localparam logic [3:0] COL_TERM1  = 4'd0;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_FLY     = 2'd1,
    S_RESOLVE = 2'd2
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [CD_W-1:0] cd_0;
  logic [CD_W-1:0] cd_1;
  logic            last_grant;
  logic [1:0]      eligible;
  logic            do_grant;
  logic            grant_owner;
  logic [3:0]      step_col;
  logic [2:0]      target_row;
  logic            row_match;

  assign dbg_state   = state;
  assign proj_active = (state != S_IDLE);

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_next;
  end

  // Next state, arbitration and next projectile column.
  always_comb begin
    state_next  = state;
    eligible    = fire_req & {cd_1 == '0, cd_0 == '0};
    do_grant    = 1'b0;
    grant_owner = (eligible == 2'b11) ? ~last_grant : eligible[1];
    step_col    = proj_owner ? (proj_col - 4'd1) : (proj_col + 4'd1);
    case (state)
      S_IDLE: begin
        if (eligible != 2'b00) begin
          do_grant   = 1'b1;
          state_next = S_FLY;
        end
      end
      S_FLY: begin
        if (tick && (step_col == (proj_owner ? COL_TERM1 : COL_TERM0))) state_next = S_RESOLVE;
      end
      S_RESOLVE: state_next = S_IDLE;
      default:   state_next = S_IDLE;
    endcase
  end

  // Projectile slot, grant pulse, round-robin memory and cooldowns.
  always_ff @(posedge clk) begin
    if (!rst) begin
      fire_grant <= 2'b00;
      proj_owner <= 1'b0;
      proj_col   <= 4'd0;
      proj_row   <= 3'd0;
      last_grant <= 1'b1;
      cd_0       <= '0;
      cd_1       <= '0;
    end else begin
      fire_grant <= 2'b00;
      if (do_grant) begin
        fire_grant <= grant_owner ? 2'b10 : 2'b01;
        last_grant <= grant_owner;
        proj_owner <= grant_owner;
        proj_row   <= grant_owner ? player_row_1 : player_row_0;
        proj_col   <= grant_owner ? COL_START1 : COL_START0;
      end else if ((state == S_FLY) && tick) begin
        proj_col <= step_col;
      end
      // A fresh grant reload wins over a same-cycle tick decrement.
      if (do_grant && !grant_owner)   cd_0 <= CD_LOAD;
      else if (tick && (cd_0 != '0))  cd_0 <= cd_0 - CD_ONE;
      if (do_grant && grant_owner)    cd_1 <= CD_LOAD;
      else if (tick && (cd_1 != '0))  cd_1 <= cd_1 - CD_ONE;
    end
  end

  // Resolution: the target row is taken live in the RESOLVE cycle.
  always_comb begin
    hit        = 2'b00;
    miss       = 1'b0;
    target_row = proj_owner ? player_row_0 : player_row_1;
    row_match  = (target_row == proj_row);
    if (state == S_RESOLVE) begin
      if (row_match) hit = proj_owner ? 2'b01 : 2'b10;
      else           miss = 1'b1;
    end
  end

endmodule

// File: tb/tb_projectile_scheduler.sv
// Bench for projectile_scheduler.
// Two instances are driven with the same inputs:
//   - default parameters (long flight);
//   - FIELD_W=4, where the cooldown outlasts the flight.
// Each cycle a reference model predicts that cycle's outputs and pushes them.
// A monitor on the falling edge pops the prediction and compares.
module tb_projectile_scheduler;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b0;
  logic       tick = 1'b0;
  logic [1:0] fire_req = 2'b00;
  logic [2:0] row0 = 3'd0;
  logic [2:0] row1 = 3'd0;

  logic [1:0] grant_a, hit_a, dbg_a;
  logic       act_a, own_a, miss_a;
  logic [3:0] col_a;
  logic [2:0] prow_a;
  logic [1:0] grant_b, hit_b, dbg_b;
  logic       act_b, own_b, miss_b;
  logic [3:0] col_b;
  logic [2:0] prow_b;

  projectile_scheduler u_dut_a (
    .clk(clk), .rst(rst), .tick(tick), .fire_req(fire_req),
    .player_row_0(row0), .player_row_1(row1),
    .fire_grant(grant_a), .proj_active(act_a), .proj_owner(own_a),
    .proj_col(col_a), .proj_row(prow_a), .hit(hit_a), .miss(miss_a),
    .dbg_state(dbg_a)
  );

  projectile_scheduler #(.FIELD_W(4), .COOLDOWN(4)) u_dut_b (
    .clk(clk), .rst(rst), .tick(tick), .fire_req(fire_req),
    .player_row_0(row0), .player_row_1(row1),
    .fire_grant(grant_b), .proj_active(act_b), .proj_owner(own_b),
    .proj_col(col_b), .proj_row(prow_b), .hit(hit_b), .miss(miss_b),
    .dbg_state(dbg_b)
  );

  // ---------------- reference model ----------------
  // Record layout: {grant[1:0], hit[1:0], miss, active, owner, col[3:0], row[2:0]}
  localparam int W = 14;
  logic [W-1:0] exp_q_a[$];
  logic [W-1:0] exp_q_b[$];

  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  bit   started = 1'b0;

  int   m_fw[2]    = '{16, 4};
  int   m_cdmax[2] = '{4, 4};
  bit   m_act[2];       // projectile exists (flying or resolving)
  bit   m_res[2];       // this cycle is the resolve cycle
  int   m_owner[2];
  int   m_col[2];
  int   m_row[2];
  int   m_cd0[2];
  int   m_cd1[2];
  int   m_last[2];
  logic [1:0] m_gp[2];  // grant pulse visible this cycle

  task automatic model_reset(input int m);
    m_act[m] = 1'b0; m_res[m] = 1'b0; m_owner[m] = 0; m_col[m] = 0; m_row[m] = 0;
    m_cd0[m] = 0; m_cd1[m] = 0; m_last[m] = 1; m_gp[m] = 2'b00;
  endtask

  // Predict outputs of the current cycle, then advance to the next edge.
  task automatic model_cycle(input int m);
    logic [1:0]   h;
    logic         ms;
    logic [W-1:0] rec;
    bit           el0, el1, granted;
    int           g;
    h = 2'b00; ms = 1'b0; granted = 1'b0; g = 0;
    if (m_res[m]) begin
      if (((m_owner[m] == 0) ? int'(row1) : int'(row0)) == m_row[m])
        h = (m_owner[m] == 0) ? 2'b10 : 2'b01;
      else
        ms = 1'b1;
    end
    rec = {m_gp[m], h, ms, m_act[m], 1'(m_owner[m]), 4'(m_col[m]), 3'(m_row[m])};
    if (m == 0) exp_q_a.push_back(rec);
    else        exp_q_b.push_back(rec);

    if (!rst) begin
      model_reset(m);
    end else begin
      el0 = fire_req[0] && (m_cd0[m] == 0);
      el1 = fire_req[1] && (m_cd1[m] == 0);
      m_gp[m] = 2'b00;
      if (m_res[m]) begin
        m_res[m] = 1'b0;
        m_act[m] = 1'b0;
      end else if (m_act[m]) begin
        if (tick) begin
          m_col[m] = m_col[m] + ((m_owner[m] == 1) ? -1 : 1);
          if (m_col[m] == ((m_owner[m] == 1) ? 0 : m_fw[m] - 1)) m_res[m] = 1'b1;
        end
      end else if (el0 || el1) begin
        g = (el0 && el1) ? 1 - m_last[m] : (el1 ? 1 : 0);
        granted    = 1'b1;
        m_owner[m] = g;
        m_row[m]   = (g == 1) ? int'(row1) : int'(row0);
        m_col[m]   = (g == 1) ? m_fw[m] - 2 : 1;
        m_act[m]   = 1'b1;
        m_gp[m]    = (g == 1) ? 2'b10 : 2'b01;
        m_last[m]  = g;
      end
      if (granted && g == 0)          m_cd0[m] = m_cdmax[m];
      else if (tick && m_cd0[m] > 0)  m_cd0[m] = m_cd0[m] - 1;
      if (granted && g == 1)          m_cd1[m] = m_cdmax[m];
      else if (tick && m_cd1[m] > 0)  m_cd1[m] = m_cd1[m] - 1;
    end
  endtask

  // ---------------- driver ----------------
  task automatic drive(input logic r, input logic t, input logic [1:0] fr,
                       input logic [2:0] a, input logic [2:0] b);
    @(posedge clk);
    #1;
    cyc = cyc + 1;
    rst = r; tick = t; fire_req = fr; row0 = a; row1 = b;
    started = 1'b1;
    model_cycle(0);
    model_cycle(1);
  endtask

  // ---------------- scoreboard / monitor ----------------
  task automatic check(input int m, input logic [W-1:0] got);
    logic [W-1:0] exp;
    n_cmp = n_cmp + 1;
    if ((m == 0 && exp_q_a.size() == 0) || (m == 1 && exp_q_b.size() == 0)) begin
      n_bad = n_bad + 1;
      $display("FAIL out_%0d cyc=%0d actual=%b required=<no prediction>", m, cyc, got);
    end else begin
      exp = (m == 0) ? exp_q_a.pop_front() : exp_q_b.pop_front();
      if (got !== exp) begin
        n_bad = n_bad + 1;
        $display("FAIL out_%0d cyc=%0d actual=%b required=%b (grant,hit,miss,act,own,col,row)",
                 m, cyc, got, exp);
      end
    end
  endtask

  always @(negedge clk) begin
    if (started) begin
      check(0, {grant_a, hit_a, miss_a, act_a, own_a, col_a, prow_a});
      check(1, {grant_b, hit_b, miss_b, act_b, own_b, col_b, prow_b});
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    model_reset(0);
    model_reset(1);
    // Reset, then a tie: player 0 must win first.
    drive(0, 0, 2'b00, 3'd3, 3'd3);
    drive(1, 0, 2'b11, 3'd3, 3'd3);
    drive(1, 1, 2'b00, 3'd3, 3'd3);
    // Fly to the end: instance A should hit player 1 at row 3.
    for (int i = 0; i < 40; i++) drive(1, (i % 2 == 0), 2'b00, 3'd3, 3'd3);
    // Tie again: player 1 is due; request held through flights is ignored.
    for (int i = 0; i < 80; i++) drive(1, (i % 2 == 1), 2'b11, 3'd3, (i < 40) ? 3'd3 : 3'd5);
    // Player 0 alone: cooldown outlasts the short flight on instance B.
    for (int i = 0; i < 60; i++) drive(1, (i % 3 == 0), 2'b01, 3'd2, 3'd2);
    // Mid-flight abort on instance A at column 7.
    for (int i = 0; i < 60 && !(m_act[0] && !m_res[0] && m_col[0] == 7); i++)
      drive(1, 1'b1, 2'b01, 3'd4, 3'd4);
    drive(0, 1'b1, 2'b00, 3'd4, 3'd4);
    drive(1, 1'b0, 2'b00, 3'd4, 3'd4);
    // Random traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(0, 299) != 0), ($urandom_range(0, 2) == 0),
            2'($urandom_range(0, 3)), 3'($urandom_range(2, 4)), 3'($urandom_range(2, 4)));
    end
    drive(1, 0, 2'b00, 3'd0, 3'd0);
    @(negedge clk);
    #1;
    // Every prediction must have been consumed.
    n_cmp = n_cmp + 1;
    if (exp_q_a.size() != 0 || exp_q_b.size() != 0) begin
      n_bad = n_bad + 1;
      $display("FAIL queue_drain actual=%0d/%0d required=0/0", exp_q_a.size(), exp_q_b.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
